// File: rtl/gas_alarm_ctrl.sv
// Gas alarm controller: confirms a persistent CH4 match on Z, then drives buzzer, valve shutoff and event count.
// Optional build macro ALARM_AUTOCLEAR_EN lets a sustained run of low Z samples end an alarm without acknowledge.
module gas_alarm_ctrl #(
    parameter int CONFIRM_CYCLES = 4,
    parameter int BEEP_HALF      = 8,
    parameter int HOLDOFF_CYCLES = 64,
    parameter int CLEAR_CYCLES   = 16,
    parameter int CNT_W          = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Z,
    input  logic             ack,
    output logic             alarm,
    output logic             buzzer,
    output logic             valve_close,
    output logic [CNT_W-1:0] alarm_cnt,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CONFIRM = 2'b01,
        ALARM   = 2'b10,
        HOLDOFF = 2'b11
    } state_t;

    localparam int RUN_W  = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
    localparam int BEEP_W = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
    localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    generate
        if (CONFIRM_CYCLES < 1 || BEEP_HALF < 1 || HOLDOFF_CYCLES < 1 || CLEAR_CYCLES < 1) begin : gBadParam
            $error("gas_alarm_ctrl: cycle parameters must be at least 1");
        end
    endgenerate

    state_t              state_q;
    logic [RUN_W-1:0]    run_q;
    logic [BEEP_W-1:0]   beep_q;
    logic [HOLD_W-1:0]   hold_q;
    logic                ack_q;
    logic                alarm_q;
    logic                buzzer_q;
    logic                valve_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                ackRise;
    logic                enterAlarm;

`ifdef ALARM_AUTOCLEAR_EN
    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    logic [CLR_W-1:0]    clr_q;
`endif

    // Alarm entry is shared by the single-sample (CONFIRM_CYCLES=1) and normal confirm paths.
    always_comb begin
        ackRise    = ack & ~ack_q;
        cnt_d      = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        enterAlarm = 1'b0;
        if (Z) begin
            if (state_q == IDLE && CONFIRM_CYCLES == 1) begin
                enterAlarm = 1'b1;
            end
            if (state_q == CONFIRM && run_q == RUN_W'(CONFIRM_CYCLES - 1)) begin
                enterAlarm = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            run_q    <= '0;
            beep_q   <= '0;
            hold_q   <= '0;
            ack_q    <= 1'b0;
            alarm_q  <= 1'b0;
            buzzer_q <= 1'b0;
            valve_q  <= 1'b0;
            cnt_q    <= '0;
`ifdef ALARM_AUTOCLEAR_EN
            clr_q    <= '0;
`endif
        end else begin
            ack_q <= ack;
            if (enterAlarm) begin
                state_q  <= ALARM;
                run_q    <= '0;
                alarm_q  <= 1'b1;
                valve_q  <= 1'b1;
                buzzer_q <= 1'b1;
                beep_q   <= '0;
                cnt_q    <= cnt_d;
`ifdef ALARM_AUTOCLEAR_EN
                clr_q    <= '0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        if (Z) begin
                            state_q <= CONFIRM;
                            run_q   <= RUN_W'(1);
                        end
                    end
                    CONFIRM: begin
                        if (!Z) begin
                            state_q <= IDLE;
                            run_q   <= '0;
                        end else begin
                            run_q <= run_q + RUN_W'(1);
                        end
                    end
                    ALARM: begin
                        // Acknowledge takes priority over auto-clear when both occur on the same edge.
                        if (ackRise) begin
                            state_q  <= HOLDOFF;
                            hold_q   <= '0;
                            alarm_q  <= 1'b0;
                            buzzer_q <= 1'b0;
`ifdef ALARM_AUTOCLEAR_EN
                        end else if (!Z && clr_q == CLR_W'(CLEAR_CYCLES - 1)) begin
                            state_q  <= IDLE;
                            alarm_q  <= 1'b0;
                            buzzer_q <= 1'b0;
                            valve_q  <= 1'b0;
                            clr_q    <= '0;
`endif
                        end else begin
`ifdef ALARM_AUTOCLEAR_EN
                            clr_q <= Z ? '0 : clr_q + CLR_W'(1);
`endif
                            if (beep_q == BEEP_W'(BEEP_HALF - 1)) begin
                                buzzer_q <= ~buzzer_q;
                                beep_q   <= '0;
                            end else begin
                                beep_q <= beep_q + BEEP_W'(1);
                            end
                        end
                    end
                    HOLDOFF: begin
                        if (hold_q == HOLD_W'(HOLDOFF_CYCLES - 1)) begin
                            state_q <= IDLE;
                            valve_q <= 1'b0;
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign alarm       = alarm_q;
    assign buzzer      = buzzer_q;
    assign valve_close = valve_q;
    assign alarm_cnt   = cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_gas_alarm_ctrl.sv
// Self-checking bench for gas_alarm_ctrl: vector table plus scoreboarded hand sequences.
// A second instance with CNT_W=2 exercises counter saturation and the single-sample confirm path.
module tb_gas_alarm_ctrl;

    typedef struct packed {
        logic       alarm;
        logic       buzzer;
        logic       valve;
        logic [7:0] cnt;
        logic [1:0] state;
    } exp_t;

    typedef struct packed {
        logic z;
        logic ack;
        exp_t exp;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Z = 1'b0;
    logic       ack = 1'b0;
    logic       z2 = 1'b0;
    logic       ack2 = 1'b0;
    logic       alarm, buzzer, valve_close;
    logic [7:0] alarm_cnt;
    logic [1:0] state_o;
    logic       alarm2, buzzer2, valve2;
    logic [1:0] cnt2;
    logic [1:0] state2;

    exp_t expQ[$];
    vec_t tbl[18];
    int   nApplied = 0;
    int   nMiss = 0;

    gas_alarm_ctrl dut (
        .CLK(CLK), .RST(RST), .Z(Z), .ack(ack),
        .alarm(alarm), .buzzer(buzzer), .valve_close(valve_close),
        .alarm_cnt(alarm_cnt), .state_o(state_o)
    );

    gas_alarm_ctrl #(.CONFIRM_CYCLES(1), .HOLDOFF_CYCLES(2), .CNT_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .Z(z2), .ack(ack2),
        .alarm(alarm2), .buzzer(buzzer2), .valve_close(valve2),
        .alarm_cnt(cnt2), .state_o(state2)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t mk(input logic a, input logic b, input logic v, input int c, input logic [1:0] s);
        exp_t e;
        e.alarm  = a;
        e.buzzer = b;
        e.valve  = v;
        e.cnt    = c[7:0];
        e.state  = s;
        return e;
    endfunction

    function automatic vec_t mkv(input logic z, input logic a, input exp_t e);
        vec_t v;
        v.z   = z;
        v.ack = a;
        v.exp = e;
        return v;
    endfunction

    // Buzzer level i cycles after alarm entry: high for the first half-period, then alternating.
    function automatic logic beepLevel(input int i);
        return ((i / 8) % 2) == 0;
    endfunction

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] expv);
        if (act !== expv) begin
            nMiss++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
        end
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (expQ.size() == 0) begin
            nMiss++;
            $display("[TB] FAIL %s: scoreboard empty, got state %0d expected a queued entry", tag, state_o);
            return;
        end
        e = expQ.pop_front();
        nApplied++;
        cmp({tag, ".alarm"},  8'(alarm),       8'(e.alarm));
        cmp({tag, ".buzzer"}, 8'(buzzer),      8'(e.buzzer));
        cmp({tag, ".valve"},  8'(valve_close), 8'(e.valve));
        cmp({tag, ".cnt"},    alarm_cnt,       e.cnt);
        cmp({tag, ".state"},  8'(state_o),     8'(e.state));
    endtask

    task automatic applyStimulus(input string tag, input logic z, input logic a, input exp_t e);
        Z   = z;
        ack = a;
        expQ.push_back(e);
        @(posedge CLK);
        #1;
        checkOutput(tag);
        @(negedge CLK);
    endtask

    task automatic checkResetState(input string tag);
        nApplied++;
        cmp({tag, ".alarm"},  8'(alarm),       8'd0);
        cmp({tag, ".buzzer"}, 8'(buzzer),      8'd0);
        cmp({tag, ".valve"},  8'(valve_close), 8'd0);
        cmp({tag, ".cnt"},    alarm_cnt,       8'd0);
        cmp({tag, ".state"},  8'(state_o),     8'd0);
    endtask

    task automatic raiseAlarm(input int c);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("confirm", 1'b1, 1'b0, mk(1'b0, 1'b0, 1'b0, c - 1, 2'b01));
        end
        applyStimulus("raise", 1'b1, 1'b0, mk(1'b1, 1'b1, 1'b1, c, 2'b10));
    endtask

    task automatic ackStep(input int c);
        applyStimulus("ack", 1'b1, 1'b1, mk(1'b0, 1'b0, 1'b1, c, 2'b11));
    endtask

    // Hold-off with Z toggling, ack held over from the acknowledge, then a fresh ack edge that must be ignored.
    task automatic runHoldoff(input int c);
        for (int j = 1; j <= 64; j++) begin
            logic a;
            a = (j <= 5) || (j >= 10 && j < 20);
            if (j < 64) applyStimulus("holdoff", j[0], a, mk(1'b0, 1'b0, 1'b1, c, 2'b11));
            else        applyStimulus("holdEnd", j[0], a, mk(1'b0, 1'b0, 1'b0, c, 2'b00));
        end
        applyStimulus("idle", 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, c, 2'b00));
    endtask

    task automatic step2(input string tag, input logic z, input logic a, input logic ea, input int ec, input logic [1:0] es);
        z2   = z;
        ack2 = a;
        @(posedge CLK);
        #1;
        nApplied++;
        cmp({tag, ".alarm2"}, 8'(alarm2), 8'(ea));
        cmp({tag, ".cnt2"},   8'(cnt2),   8'(ec));
        cmp({tag, ".state2"}, 8'(state2), 8'(es));
        @(negedge CLK);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0] = mkv(1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 0, 2'b00));
        for (int i = 1; i <= 3; i++) tbl[i] = mkv(1'b1, 1'b0, mk(1'b0, 1'b0, 1'b0, 0, 2'b01));
        tbl[4] = mkv(1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 0, 2'b00));
        for (int i = 5; i <= 7; i++) tbl[i] = mkv(1'b1, 1'b0, mk(1'b0, 1'b0, 1'b0, 0, 2'b01));
        for (int i = 8; i <= 15; i++) tbl[i] = mkv(1'b1, 1'b0, mk(1'b1, 1'b1, 1'b1, 1, 2'b10));
        tbl[16] = mkv(1'b1, 1'b0, mk(1'b1, 1'b0, 1'b1, 1, 2'b10));
        tbl[17] = mkv(1'b1, 1'b1, mk(1'b0, 1'b0, 1'b1, 1, 2'b11));

        repeat (2) @(posedge CLK);
        #1;
        checkResetState("reset");
        @(negedge CLK);
        RST = 1'b1;

        // Confirm restart on a single low sample, alarm entry, first buzzer half-period, acknowledge.
        for (int i = 0; i < 18; i++) begin
            applyStimulus("table", tbl[i].z, tbl[i].ack, tbl[i].exp);
        end
        runHoldoff(1);

        RST = 1'b0;
        #1;
        checkResetState("reset2");
        @(negedge CLK);
        RST = 1'b1;

        raiseAlarm(1);
        for (int i = 1; i <= 40; i++) begin
            applyStimulus("beep", 1'b1, 1'b0, mk(1'b1, beepLevel(i), 1'b1, 1, 2'b10));
        end
        ackStep(1);
        runHoldoff(1);
        raiseAlarm(2);
        ackStep(2);
        runHoldoff(2);
        raiseAlarm(3);

        // Asynchronous reset in the middle of a clock period while alarmed.
        #2;
        RST = 1'b0;
        #1;
        checkResetState("rstMid");
        @(negedge CLK);
        RST = 1'b1;

        raiseAlarm(1);
        for (int i = 1; i <= 15; i++) begin
            applyStimulus("lowZ", 1'b0, 1'b0, mk(1'b1, beepLevel(i), 1'b1, 1, 2'b10));
        end
        applyStimulus("ackOnClear", 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b1, 1, 2'b11));
        runHoldoff(1);

        raiseAlarm(2);
        for (int i = 1; i <= 15; i++) begin
            applyStimulus("lowZ2", 1'b0, 1'b0, mk(1'b1, beepLevel(i), 1'b1, 2, 2'b10));
        end
`ifdef ALARM_AUTOCLEAR_EN
        applyStimulus("autoClear", 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 2, 2'b00));
`else
        applyStimulus("noClear", 1'b0, 1'b0, mk(1'b1, beepLevel(16), 1'b1, 2, 2'b10));
        ackStep(2);
        runHoldoff(2);
`endif

        for (int k = 1; k <= 5; k++) begin
            step2("sat.raise", 1'b1, 1'b0, 1'b1, (k > 3) ? 3 : k, 2'b10);
            step2("sat.ack",   1'b0, 1'b1, 1'b0, (k > 3) ? 3 : k, 2'b11);
            step2("sat.hold",  1'b0, 1'b0, 1'b0, (k > 3) ? 3 : k, 2'b11);
            step2("sat.idle",  1'b0, 1'b0, 1'b0, (k > 3) ? 3 : k, 2'b00);
        end

        if (expQ.size() != 0) begin
            nMiss++;
            $display("[TB] FAIL scoreboard drain: got %0d entries left, expected 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
        $finish;
    end

endmodule

// File: doc/gas_alarm_ctrl.md
# gas_alarm_ctrl

Alarm controller directly downstream of the CH4 serial sequence detector in the smart home system. Consumes the detector's one-bit match output Z, requires it to persist before declaring a gas alarm, then drives the buzzer, the gas valve shutoff and an event counter. A user acknowledge silences the alarm, followed by a hold-off window.

## Interface
- CONFIRM_CYCLES, 4: consecutive high Z samples required to raise the alarm (≥1)
- BEEP_HALF, 8: buzzer half-period in CLK cycles (≥1)
- HOLDOFF_CYCLES, 64: post-acknowledge hold-off length in CLK cycles (≥1)
- CLEAR_CYCLES, 16: consecutive low Z samples for auto-clear (used only with ALARM_AUTOCLEAR_EN)
- CNT_W, 8: width of alarm event counter
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-low
- Z  in  1  detector match output, synchronous to CLK
- ack  in  1  user acknowledge, level; rising edge detected internally
- alarm  out  1  alarm active
- buzzer  out  1  buzzer drive, square wave while alarmed
- valve_close  out  1  gas valve shutoff request
- alarm_cnt  out  CNT_W  number of alarms raised, saturating
- state_o  out  2  current FSM state encoding

## Operation
- States: IDLE=2'b00, CONFIRM=2'b01, ALARM=2'b10, HOLDOFF=2'b11; state_o = state.
- ack edge: ack_q registered each cycle; ack_rise = ack & ~ack_q.
- IDLE: Z=1 → CONFIRM, run=1; with CONFIRM_CYCLES=1, go straight to ALARM instead.
- CONFIRM: Z=0 → IDLE, run=0. Z=1 and run==CONFIRM_CYCLES-1 → ALARM. Else run+1.
- ALARM entry: alarm=1, valve_close=1, buzzer=1, beep timer=0, alarm_cnt+1 saturating at 2^CNT_W-1.
- ALARM: buzzer inverts every BEEP_HALF cycles. ack_rise → HOLDOFF, hold timer=0. Z ignored except for auto-clear.
- HOLDOFF: alarm=0, buzzer=0, valve_close stays 1; Z and ack ignored; after HOLDOFF_CYCLES cycles → IDLE with valve_close=0.
- Simultaneous ack_rise and auto-clear condition in ALARM: ack wins (HOLDOFF).
- All outputs registered; no combinational path from Z/ack to outputs.

## Timing
- Reset (RST=0, any time, including mid-alarm): state=IDLE, alarm=0, buzzer=0, valve_close=0, alarm_cnt=0, run/timers=0, ack_q=0.
- Alarm latency: Z high on edges k..k+CONFIRM_CYCLES-1 → alarm=1 after edge k+CONFIRM_CYCLES-1.
- One low Z sample in CONFIRM restarts the count; the next high sample re-enters with run=1.
- Buzzer: high for first BEEP_HALF cycles of ALARM, then low for BEEP_HALF, repeating.
- ack_rise sampled on edge n in ALARM → alarm=0, buzzer=0 after edge n.
- HOLDOFF entered on edge n → IDLE and valve_close=0 after edge n+HOLDOFF_CYCLES.
- ack held high continuously gives exactly one ack_rise.
- ack_rise outside ALARM has no effect; it is not remembered.

## Configuration
- ALARM_AUTOCLEAR_EN defined: in ALARM, a clear counter counts consecutive Z=0 samples and resets on Z=1. Reaching CLEAR_CYCLES → IDLE directly, with alarm=0, buzzer=0, valve_close=0 and no hold-off.
- Undefined: no clear counter; ALARM exits only via ack_rise or reset. CLEAR_CYCLES unused.

## Test plan
- Reset then Z=1 for 4 cycles (defaults) → alarm=1, valve_close=1, buzzer=1, alarm_cnt=1, state_o=2'b10 after 4th edge.
- Z pattern 1,1,1,0,1,1,1,1 → no alarm through the 0; alarm asserts on the 8th edge.
- In ALARM for 40 cycles → buzzer toggles every 8 cycles (5 half-periods); ack pulse → alarm=0, buzzer=0, state_o=2'b11; valve_close falls exactly 64 cycles later; Z=1 during hold-off has no effect.
- RST low mid-ALARM with alarm_cnt=3 → all outputs 0, alarm_cnt=0 immediately (asynchronous).
- CNT_W=2, five alarm/ack cycles → alarm_cnt saturates at 3.
- ALARM_AUTOCLEAR_EN: alarm then Z=0 for 16 cycles → IDLE, valve_close=0. Without macro: same stimulus keeps alarm=1. With macro, ack on the 16th low cycle → HOLDOFF.
